// File: rtl/prog_mod_counter.sv
// prog_mod_counter
// Programmable modulo up/down counter with wrap or saturate behaviour at the
// count boundaries, a synchronous load port with illegal-value detection, and
// compare / terminal-count flags.
//
// Parameters
//   WIDTH     count register width in bits (2..16)
//   MODULUS   count range is 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   reset_n    asynchronous active-low reset (deassertion synchronised outside)
//   en         count enable
//   up         direction: 1 counts up, 0 counts down
//   sat        boundary mode: 0 wraps, 1 saturates
//   load       synchronous load strobe (takes priority over en)
//   load_val   value to load; values >= MODULUS are rejected
//   match_val  compare value for match
//   count      registered count
//   match      combinational: count == match_val, suppressed while load is high
//   tc         combinational terminal count for the current direction
//   wrapped    registered one-cycle pulse following a wrap transition
//   load_err   sticky flag set by an illegal load, cleared by a legal load
module prog_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] match_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);

    // Modulus is held one bit wider than the count so MODULUS == 2**WIDTH
    // is representable and the legal-load compare does not overflow.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   count_ext;
    logic [WIDTH-1:0] count_next;
    logic             wrapped_next;
    logic             load_err_next;
    logic             at_top;
    logic             at_bot;
    logic             load_ok;

    assign count_ext = {1'b0, count};
    assign at_top    = (count == MAX_VAL);
    assign at_bot    = (count == '0);
    assign load_ok   = ({1'b0, load_val} < MOD_EXT);

    // Mealy flags: both are masked by load because a load overrides the
    // count that would otherwise be reported this cycle.
    assign tc    = en & ~load & (up ? at_top : at_bot);
    assign match = (count == match_val) & ~load;

    // Next-state selection: load beats en, en beats hold. Increment and
    // decrement are computed one bit wider and then truncated; the boundary
    // cases are handled explicitly so the truncation never discards a value
    // that should have been kept.
    always_comb begin
        count_next    = count;
        wrapped_next  = 1'b0;
        load_err_next = load_err;

        if (load) begin
            if (load_ok) begin
                count_next    = load_val;
                load_err_next = 1'b0;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    if (!sat) begin
                        count_next   = '0;
                        wrapped_next = 1'b1;
                    end
                end else begin
                    count_next = WIDTH'(count_ext + (WIDTH+1)'(1));
                end
            end else begin
                if (at_bot) begin
                    if (!sat) begin
                        count_next   = MAX_VAL;
                        wrapped_next = 1'b1;
                    end
                end else begin
                    count_next = WIDTH'(count_ext - (WIDTH+1)'(1));
                end
            end
        end
    end

    // State registers; reset clears everything immediately, independent of clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_next;
            wrapped  <= wrapped_next;
            load_err <= load_err_next;
        end
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb_prog_mod_counter
// Directed bench for prog_mod_counter. Three instances cover MODULUS=4
// (defaults), MODULUS=10 and MODULUS=16 (full-width carry), all WIDTH=4.
// Each vector drives one instance for one clock cycle and carries the
// hand-computed outputs expected in that cycle (present count plus Mealy
// flags). Expected entries go into a queue; an independent monitor pops and
// compares them mid-cycle.
module tb_prog_mod_counter;

    typedef struct {
        int         idx;
        string      name;
        logic [3:0] count;
        logic       match;
        logic       tc;
        logic       wrapped;
        logic       load_err;
    } exp_t;

    exp_t sbq[$];

    int applied  = 0;
    int checked  = 0;
    int errors   = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en[3];
    logic       up[3];
    logic       sat[3];
    logic       load[3];
    logic [3:0] load_val[3];
    logic [3:0] match_val[3];
    logic [3:0] count[3];
    logic       match[3];
    logic       tc[3];
    logic       wrapped[3];
    logic       load_err[3];

    always #5 clk = ~clk;

    prog_mod_counter #(.WIDTH(4), .MODULUS(4)) u_m4 (
        .clk(clk), .reset_n(reset_n), .en(en[0]), .up(up[0]), .sat(sat[0]),
        .load(load[0]), .load_val(load_val[0]), .match_val(match_val[0]),
        .count(count[0]), .match(match[0]), .tc(tc[0]),
        .wrapped(wrapped[0]), .load_err(load_err[0])
    );

    prog_mod_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .clk(clk), .reset_n(reset_n), .en(en[1]), .up(up[1]), .sat(sat[1]),
        .load(load[1]), .load_val(load_val[1]), .match_val(match_val[1]),
        .count(count[1]), .match(match[1]), .tc(tc[1]),
        .wrapped(wrapped[1]), .load_err(load_err[1])
    );

    prog_mod_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .reset_n(reset_n), .en(en[2]), .up(up[2]), .sat(sat[2]),
        .load(load[2]), .load_val(load_val[2]), .match_val(match_val[2]),
        .count(count[2]), .match(match[2]), .tc(tc[2]),
        .wrapped(wrapped[2]), .load_err(load_err[2])
    );

    // Drive one vector at the falling edge and queue its expectation.
    // rst: 0 = reset released, 1 = reset held low for the whole cycle,
    //      2 = reset pulsed low between edges (released before the rising edge).
    task automatic applyStimulus(input int idx, input int rst,
                                 input logic e, input logic u, input logic s,
                                 input logic l, input logic [3:0] lv,
                                 input logic [3:0] mv, input logic [3:0] ec,
                                 input logic em, input logic et,
                                 input logic ew, input logic ee,
                                 input string name);
        exp_t x;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            en[i]   = 1'b0;
            load[i] = 1'b0;
            up[i]   = 1'b1;
            sat[i]  = 1'b0;
        end
        en[idx]        = e;
        up[idx]        = u;
        sat[idx]       = s;
        load[idx]      = l;
        load_val[idx]  = lv;
        match_val[idx] = mv;
        reset_n        = (rst == 0);
        x.idx      = idx;
        x.name     = name;
        x.count    = ec;
        x.match    = em;
        x.tc       = et;
        x.wrapped  = ew;
        x.load_err = ee;
        sbq.push_back(x);
        applied++;
        if (rst == 2) begin
            #3;
            reset_n = 1'b1;
        end
    endtask

    task automatic checkOutput(input exp_t x);
        checked++;
        if (count[x.idx] !== x.count || match[x.idx] !== x.match ||
            tc[x.idx] !== x.tc || wrapped[x.idx] !== x.wrapped ||
            load_err[x.idx] !== x.load_err) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d match=%b tc=%b wrapped=%b load_err=%b, required count=%0d match=%b tc=%b wrapped=%b load_err=%b",
                     x.name, count[x.idx], match[x.idx], tc[x.idx],
                     wrapped[x.idx], load_err[x.idx], x.count, x.match,
                     x.tc, x.wrapped, x.load_err);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample 2ns after the
    // falling edge, well clear of the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                checkOutput(x);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; up[i] = 1'b1; sat[i] = 1'b0; load[i] = 1'b0;
            load_val[i] = 4'd0; match_val[i] = 4'd0;
        end

        // MODULUS=4: reset behaviour, Mealy flags from count=0 during reset
        //           idx rst en up sat ld lv     mv     cnt    m  t  w  e
        applyStimulus(0, 1, 1, 1, 0, 0, 4'd0, 4'd2, 4'd0, 0, 0, 0, 0, "rst_hold_up");
        applyStimulus(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, "rst_hold_down_tc");
        // Count up with wrap from reset: 0 -> 1,2,3,0,1,2
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd0, 0, 0, 0, 0, "up_c0");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, "up_c1");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd2, 1, 0, 0, 0, "up_c2_match");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd3, 0, 1, 0, 0, "up_c3_tc");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd0, 0, 0, 1, 0, "up_wrap_pulse");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, "up_c1_again");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd2, 1, 0, 0, 0, "up_c2_again");
        // Illegal load at count=3, then async reset pulse clears everything
        applyStimulus(0, 0, 1, 1, 0, 1, 4'd7, 4'd2, 4'd3, 0, 0, 0, 0, "bad_load_at_3");
        applyStimulus(0, 2, 1, 1, 0, 0, 4'd0, 4'd2, 4'd0, 0, 0, 0, 0, "async_reset_pulse");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, "first_edge_after_rst");
        // Load sequence: illegal then legal
        applyStimulus(0, 0, 1, 1, 0, 1, 4'd7, 4'd2, 4'd2, 0, 0, 0, 0, "load7_cycle");
        applyStimulus(0, 0, 0, 1, 0, 1, 4'd1, 4'd2, 4'd2, 0, 0, 0, 1, "load_err_set");
        applyStimulus(0, 0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd1, 1, 0, 0, 0, "load1_accepted");
        // Load on boundary while enabled
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd1, 1, 0, 0, 0, "pre_bnd_c1");
        applyStimulus(0, 0, 1, 1, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0, 0, "pre_bnd_c2");
        applyStimulus(0, 0, 1, 1, 0, 1, 4'd2, 4'd3, 4'd3, 0, 0, 0, 0, "load_on_boundary");
        applyStimulus(0, 0, 0, 1, 0, 0, 4'd0, 4'd2, 4'd2, 1, 0, 0, 0, "load_bnd_result");
        // Count down with wrap
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd2, 0, 0, 0, 0, "down_c2");
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd1, 0, 0, 0, 0, "down_c1");
        applyStimulus(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, "down_c0_tc");
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd3, 0, 0, 1, 0, "down_wrap_pulse");
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd3, 0, 0, 0, 0, "wrap_pulse_ends");
        // Saturate up at MODULUS-1, then direction change same cycle
        applyStimulus(0, 0, 1, 1, 1, 0, 4'd0, 4'd3, 4'd3, 1, 1, 0, 0, "sat_up_1");
        applyStimulus(0, 0, 1, 1, 1, 0, 4'd0, 4'd3, 4'd3, 1, 1, 0, 0, "sat_up_2");
        applyStimulus(0, 0, 1, 0, 1, 0, 4'd0, 4'd3, 4'd3, 1, 0, 0, 0, "dir_flip_tc");
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd0, 4'd3, 4'd2, 0, 0, 0, 0, "dir_flip_result");

        // MODULUS=10: saturate down from 1, illegal load of 10, wrap at 9
        applyStimulus(1, 0, 0, 1, 0, 1, 4'd1, 4'd9, 4'd0, 0, 0, 0, 0, "m10_load1");
        applyStimulus(1, 0, 1, 0, 1, 0, 4'd0, 4'd9, 4'd1, 0, 0, 0, 0, "m10_sat_c1");
        applyStimulus(1, 0, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0, 0, "m10_sat_0a");
        applyStimulus(1, 0, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0, 0, "m10_sat_0b");
        applyStimulus(1, 0, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0, 0, "m10_sat_0c");
        applyStimulus(1, 0, 0, 1, 0, 1, 4'd10, 4'd0, 4'd0, 0, 0, 0, 0, "m10_load10");
        applyStimulus(1, 0, 0, 1, 0, 1, 4'd9, 4'd0, 4'd0, 0, 0, 0, 1, "m10_err_load9");
        applyStimulus(1, 0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd9, 1, 1, 0, 0, "m10_c9_tc");
        applyStimulus(1, 0, 0, 1, 0, 0, 4'd0, 4'd9, 4'd0, 0, 0, 1, 0, "m10_wrap");

        // MODULUS=16: full-width carry both directions
        applyStimulus(2, 0, 0, 1, 0, 1, 4'd15, 4'd0, 4'd0, 0, 0, 0, 0, "m16_load15");
        applyStimulus(2, 0, 1, 1, 0, 0, 4'd0, 4'd15, 4'd15, 1, 1, 0, 0, "m16_c15_tc");
        applyStimulus(2, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0, 1, 0, "m16_carry_wrap");
        applyStimulus(2, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, "m16_down_c0_tc");
        applyStimulus(2, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd15, 0, 0, 1, 0, "m16_borrow_wrap");
        applyStimulus(2, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd15, 0, 0, 0, 0, "m16_hold");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
        end
        if (checked != applied) begin
            errors++;
            $display("[TB] FAIL check_count: got %0d checked, required %0d", checked, applied);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
